// File: rtl/band_power_scheduler_if.sv
// Bus bundle between the EEG FFT channels, the shared power calculator,
// the result consumer and band_power_scheduler.
// slave  : seen from the scheduler.
// master : seen from the environment that surrounds the scheduler.
interface band_power_scheduler_if #(
    parameter int NUM_CH = 4
) ();
    localparam int CW = $clog2(NUM_CH);

    // Channel request / grant and the per-channel FFT bin streams
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH-1:0]    ch_grant;
    logic [NUM_CH-1:0]    s_valid;
    logic [NUM_CH*32-1:0] s_real;
    logic [NUM_CH*32-1:0] s_imag;

    // Power calculator drive and its result
    logic                 pc_en;
    logic                 pc_valid;
    logic [31:0]          pc_real;
    logic [31:0]          pc_imag;
    logic                 pc_power_valid;
    logic [159:0]         pc_bands;

    // Result handshake and status
    logic                 res_valid;
    logic                 res_ready;
    logic [CW-1:0]        res_ch;
    logic [159:0]         res_bands;
    logic [15:0]          frames_done;
    logic                 timeout_err;

    modport slave (
        input  ch_req, s_valid, s_real, s_imag, pc_power_valid, pc_bands, res_ready,
        output ch_grant, pc_en, pc_valid, pc_real, pc_imag,
               res_valid, res_ch, res_bands, frames_done, timeout_err
    );

    modport master (
        output ch_req, s_valid, s_real, s_imag, pc_power_valid, pc_bands, res_ready,
        input  ch_grant, pc_en, pc_valid, pc_real, pc_imag,
               res_valid, res_ch, res_bands, frames_done, timeout_err
    );
endinterface

// File: rtl/band_power_scheduler.sv
// band_power_scheduler: time-shares one band-power calculator between
// NUM_CH EEG FFT channel streams. Round-robin grant, zero-latency bin
// forwarding from the granted channel, result held until accepted.
// Optional macro BPS_TIMEOUT_EN adds a STREAM watchdog that abandons a
// frame after TIMEOUT_CYCLES cycles without a calculator result.
module band_power_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int EPOCH_LENGTH   = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                   clk,
    input logic                   rst_n,
    band_power_scheduler_if.slave bus
);
    localparam int CW = $clog2(NUM_CH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_OUT    = 2'd2;

    // One past the number of valid bins in an epoch half; counter stops here
    localparam logic [8:0] BIN_SAT = 9'(EPOCH_LENGTH / 2 + 2);

    logic [1:0]        state_q,       state_d;
    logic [CW-1:0]     last_grant_q,  last_grant_d;
    logic [8:0]        bin_cnt_q,     bin_cnt_d;
    logic [15:0]       frames_done_q, frames_done_d;
    logic              res_valid_q,   res_valid_d;
    logic [CW-1:0]     res_ch_q,      res_ch_d;
    logic [159:0]      res_bands_q,   res_bands_d;
    logic [NUM_CH-1:0] ch_grant_q,    ch_grant_d;
    logic              pc_en_q,       pc_en_d;

    logic              pick_found_s;
    logic [CW-1:0]     pick_idx_s;
    logic              pc_valid_s;
    logic [31:0]       pc_real_s;
    logic [31:0]       pc_imag_s;

`ifdef BPS_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_err_q, timeout_err_d;
`endif

    // Round-robin search starting one above the last granted channel
    always_comb begin
        logic [CW-1:0] cand_s;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand_s = CW'((int'(last_grant_q) + i) % NUM_CH);
            if (!pick_found_s && bus.ch_req[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Zero-latency mux of the granted channel's bins; quiet outside STREAM
    always_comb begin
        pc_valid_s = 1'b0;
        pc_real_s  = 32'd0;
        pc_imag_s  = 32'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            if ((state_q == ST_STREAM) && (CW'(k) == last_grant_q)) begin
                pc_valid_s = bus.s_valid[k];
                pc_real_s  = bus.s_real[k*32 +: 32];
                pc_imag_s  = bus.s_imag[k*32 +: 32];
            end else begin
                pc_valid_s = pc_valid_s;
            end
        end
    end

    // Frame FSM next-state and registered-output next values
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        bin_cnt_d     = bin_cnt_q;
        frames_done_d = frames_done_q;
        res_valid_d   = res_valid_q;
        res_ch_d      = res_ch_q;
        res_bands_d   = res_bands_q;
        ch_grant_d    = ch_grant_q;
        pc_en_d       = pc_en_q;
`ifdef BPS_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                ch_grant_d = '0;
                pc_en_d    = 1'b0;
                if (pick_found_s) begin
                    state_d                = ST_STREAM;
                    last_grant_d           = pick_idx_s;
                    ch_grant_d[pick_idx_s] = 1'b1;
                    pc_en_d                = 1'b1;
                    bin_cnt_d              = 9'd0;
`ifdef BPS_TIMEOUT_EN
                    tmo_cnt_d              = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (pc_valid_s && (bin_cnt_q != BIN_SAT)) begin
                    bin_cnt_d = bin_cnt_q + 9'd1;
                end else begin
                    bin_cnt_d = bin_cnt_q;
                end
`ifdef BPS_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + TW'(1);
`endif
                // A result arriving in the expiry cycle is still captured
                if (bus.pc_power_valid) begin
                    res_bands_d = bus.pc_bands;
                    res_ch_d    = last_grant_q;
                    res_valid_d = 1'b1;
                    ch_grant_d  = '0;
                    state_d     = ST_OUT;
                end
`ifdef BPS_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    ch_grant_d    = '0;
                    pc_en_d       = 1'b0;
                    state_d       = ST_IDLE;
                end
`endif
                else begin
                    state_d = ST_STREAM;
                end
            end
            ST_OUT: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d   = 1'b0;
                    pc_en_d       = 1'b0;
                    frames_done_d = frames_done_q + 16'd1;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                ch_grant_d  = '0;
                pc_en_d     = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= CW'(NUM_CH - 1);
            bin_cnt_q     <= 9'd0;
            frames_done_q <= 16'd0;
            res_valid_q   <= 1'b0;
            res_ch_q      <= '0;
            res_bands_q   <= 160'd0;
            ch_grant_q    <= '0;
            pc_en_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            bin_cnt_q     <= bin_cnt_d;
            frames_done_q <= frames_done_d;
            res_valid_q   <= res_valid_d;
            res_ch_q      <= res_ch_d;
            res_bands_q   <= res_bands_d;
            ch_grant_q    <= ch_grant_d;
            pc_en_q       <= pc_en_d;
        end
    end

`ifdef BPS_TIMEOUT_EN
    // Watchdog counter and one-cycle error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.ch_grant    = ch_grant_q;
    assign bus.pc_en       = pc_en_q;
    assign bus.pc_valid    = pc_valid_s;
    assign bus.pc_real     = pc_real_s;
    assign bus.pc_imag     = pc_imag_s;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_ch      = res_ch_q;
    assign bus.res_bands   = res_bands_q;
    assign bus.frames_done = frames_done_q;
endmodule
